// File: rtl/lmem_arbiter_if.sv
// Requester/memory-side signal bundle for the layer-memory arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus memory.
interface lmem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 20
) ();
  logic [2:0]      req;
  logic [2:0]      lock;
  logic [2:0]      we;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [8:0]      req_sel;
  logic [2:0]      gnt;
  logic [2:0]      rvalid;
  logic [DW-1:0]   rdata;
  logic            cwr;
  logic [AW-1:0]   caddr_wr;
  logic [DW-1:0]   cdata_wr;
  logic            crd;
  logic [AW-1:0]   caddr_rd;
  logic [DW-1:0]   cdata_rd;
  logic [2:0]      csel;

  modport slave (
    input  req, lock, we, req_addr, req_wdata, req_sel, cdata_rd,
    output gnt, rvalid, rdata, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

  modport master (
    output req, lock, we, req_addr, req_wdata, req_sel, cdata_rd,
    input  gnt, rvalid, rdata, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );
endinterface

// File: rtl/lmem_arbiter.sv
// Three-requester round-robin arbiter for a single layer-memory port with
// lockable bursts of up to MAX_BURST accesses and a 1-cycle read return.
module lmem_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 20,
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  lmem_arbiter_if.slave bus
);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t        r_state;
  logic [1:0]    r_owner;
  logic [1:0]    r_ptr;
  logic [3:0]    r_cnt;
  logic [2:0]    r_gnt;
  logic [2:0]    r_rvalid;
  logic [DW-1:0] r_rdata;

  logic [AW-1:0] w_addr  [3];
  logic [DW-1:0] w_wdata [3];
  logic [2:0]    w_sel   [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
    assign w_addr[gi]  = bus.req_addr[gi*AW +: AW];
    assign w_wdata[gi] = bus.req_wdata[gi*DW +: DW];
    assign w_sel[gi]   = bus.req_sel[gi*3 +: 3];
  end

  // First requester with req high, searching ptr, ptr+1, ptr+2 (mod 3).
  function automatic logic [1:0] pick(input logic [2:0] rq, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] win;
    win = p;
    for (int k = 2; k >= 0; k--) begin
      idx = 2'((32'(p) + k) % 3);
      if (rq[idx]) win = idx;
    end
    return win;
  endfunction

  logic          w_access;
  logic          w_wr;
  logic          w_rd;
  logic [3:0]    w_cnt_inc;
  logic          w_last;
  logic [1:0]    w_ptr_next;
  logic [1:0]    w_winner;

  assign w_access   = (r_state == S_OWN) && bus.req[r_owner];
  assign w_wr       = w_access && bus.we[r_owner];
  assign w_rd       = w_access && !bus.we[r_owner];
  assign w_cnt_inc  = r_cnt + 4'd1;
  assign w_last     = !bus.lock[r_owner] || (w_cnt_inc == 4'(MAX_BURST));
  assign w_ptr_next = (r_owner == 2'd2) ? 2'd0 : r_owner + 2'd1;
  assign w_winner   = pick(bus.req, r_ptr);

  // Memory-side strobes follow the owner's live request in the same cycle.
  assign bus.cwr      = w_wr;
  assign bus.crd      = w_rd;
  assign bus.caddr_wr = w_wr ? w_addr[r_owner] : '0;
  assign bus.cdata_wr = w_wr ? w_wdata[r_owner] : '0;
  assign bus.caddr_rd = w_rd ? w_addr[r_owner] : '0;
  assign bus.csel     = w_access ? w_sel[r_owner] : '0;

  assign bus.gnt    = r_gnt;
  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = r_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_owner  <= 2'd0;
      r_ptr    <= 2'd0;
      r_cnt    <= 4'd0;
      r_gnt    <= 3'b000;
      r_rvalid <= 3'b000;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= 3'b000;
      case (r_state)
        S_IDLE: begin
          if (bus.req != 3'b000) begin
            r_state <= S_OWN;
            r_owner <= w_winner;
            r_cnt   <= 4'd0;
            r_gnt   <= 3'b001 << w_winner;
          end
        end
        S_OWN: begin
          if (w_access) begin
            r_cnt <= w_cnt_inc;
            if (w_rd) begin
              r_rdata  <= bus.cdata_rd;
              r_rvalid <= 3'b001 << r_owner;
            end
            if (w_last) begin
              r_state <= S_IDLE;
              r_gnt   <= 3'b000;
              r_ptr   <= w_ptr_next;
            end
          end else begin
            // Owner withdrew its request: release without an access.
            r_state <= S_IDLE;
            r_gnt   <= 3'b000;
            r_ptr   <= w_ptr_next;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lmem_arbiter.sv
// Self-checking bench for lmem_arbiter: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural arbitration model.
module tb_lmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 20;
  localparam int MAXB = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  lmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  lmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: m_own < 0 means nobody holds the port.
  int            m_own;
  int            m_ptr;
  int            m_cnt;
  logic [DW-1:0] m_rdata;
  logic [2:0]    m_rvalid;

  logic [2:0] gtbl [8];
  logic       wtbl [8];
  int         atbl [8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_own    = -1;
    m_ptr    = 0;
    m_cnt    = 0;
    m_rdata  = '0;
    m_rvalid = '0;
  endtask

  task automatic m_update();
    logic [2:0] nrv;
    bit found;
    nrv = 3'b000;
    if (m_own < 0) begin
      found = 0;
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (m_ptr + k) % 3;
        if (!found && bus.req[c]) begin
          m_own = c;
          found = 1;
        end
      end
      m_cnt = 0;
    end else if (bus.req[m_own]) begin
      m_cnt++;
      if (!bus.we[m_own]) begin
        m_rdata = bus.cdata_rd;
        nrv = 3'b001 << m_own;
      end
      if (!bus.lock[m_own] || m_cnt == MAXB) begin
        m_ptr = (m_own + 1) % 3;
        m_own = -1;
      end
    end else begin
      m_ptr = (m_own + 1) % 3;
      m_own = -1;
    end
    m_rvalid = nrv;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    int o;
    bit acc;
    logic [2:0] e_gnt;
    #1;
    if (!reset) m_reset();
    o     = (m_own < 0) ? 0 : m_own;
    acc   = (m_own >= 0) && bus.req[o];
    e_gnt = (m_own < 0) ? 3'b000 : (3'b001 << o);
    chk("gnt",      64'(bus.gnt),      64'(e_gnt));
    chk("rvalid",   64'(bus.rvalid),   64'(m_rvalid));
    chk("rdata",    64'(bus.rdata),    64'(m_rdata));
    chk("cwr",      64'(bus.cwr),      64'(acc && bus.we[o]));
    chk("crd",      64'(bus.crd),      64'(acc && !bus.we[o]));
    chk("caddr_wr", 64'(bus.caddr_wr), (acc && bus.we[o])  ? 64'(bus.req_addr[o*AW +: AW]) : 64'd0);
    chk("caddr_rd", 64'(bus.caddr_rd), (acc && !bus.we[o]) ? 64'(bus.req_addr[o*AW +: AW]) : 64'd0);
    chk("cdata_wr", 64'(bus.cdata_wr), (acc && bus.we[o])  ? 64'(bus.req_wdata[o*DW +: DW]) : 64'd0);
    chk("csel",     64'(bus.csel),     acc ? 64'(bus.req_sel[o*3 +: 3]) : 64'd0);
    if (reset) m_update();
    @(negedge clk);
  endtask

  task automatic set_in(input logic [2:0] rq, input logic [2:0] lk, input logic [2:0] w);
    bus.req  = rq;
    bus.lock = lk;
    bus.we   = w;
  endtask

  initial begin
    int a;
    n_checks = 0;
    n_err    = 0;
    reset    = 1'b0;
    set_in(3'b000, 3'b000, 3'b000);
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_sel   = '0;
    bus.cdata_rd  = '0;
    m_reset();
    gtbl = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    wtbl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    atbl = '{0, 10, 11, 12, 13, 0, 14, 15};

    // Reset state, including requests present while in reset.
    @(negedge clk);
    step();
    bus.req = 3'b111;
    step();
    bus.req = 3'b000;
    reset = 1'b1;
    step();

    // All three requesting, unlocked reads: round-robin with idle gaps.
    for (int i = 0; i < 8; i++) begin
      set_in(3'b111, 3'b000, 3'b000);
      bus.req_addr = {12'd3, 12'd2, 12'd1};
      #1;
      chk("rr_gnt", 64'(bus.gnt), 64'(gtbl[i]));
      chk("rr_crd", 64'(bus.crd), 64'(gtbl[i] != 3'b000));
      step();
    end
    set_in(3'b000, 3'b000, 3'b000);
    step();

    // Requester 1 locked write burst capped at MAX_BURST.
    a = 10;
    for (int i = 0; i < 8; i++) begin
      set_in(3'b010, 3'b010, 3'b010);
      bus.req_addr  = '0;
      bus.req_addr[AW +: AW] = AW'(a);
      bus.req_wdata = '0;
      bus.req_wdata[DW +: DW] = DW'(a * 7);
      #1;
      chk("burst_cwr",  64'(bus.cwr),      64'(wtbl[i]));
      chk("burst_addr", 64'(bus.caddr_wr), 64'(atbl[i]));
      if (wtbl[i]) a++;
      step();
    end
    set_in(3'b000, 3'b010, 3'b010);
    step();

    // Requester 2 read with 1-cycle return.
    set_in(3'b100, 3'b000, 3'b000);
    bus.req_addr = '0;
    bus.req_addr[2*AW +: AW] = AW'(5);
    bus.req_sel  = 9'b011_000_000;
    bus.cdata_rd = 20'h0ABCD;
    step();
    #1;
    chk("rd_crd",  64'(bus.crd),      64'd1);
    chk("rd_addr", 64'(bus.caddr_rd), 64'd5);
    step();
    set_in(3'b000, 3'b000, 3'b000);
    bus.cdata_rd = 20'h11111;
    #1;
    chk("rd_rvalid", 64'(bus.rvalid), 64'(3'b100));
    chk("rd_rdata",  64'(bus.rdata),  64'(20'h0ABCD));
    step();

    // Reset pulse during a read access suppresses rvalid; fresh search from 0.
    set_in(3'b001, 3'b000, 3'b000);
    step();
    #1;
    reset = 1'b0;
    step();
    #1;
    chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
    step();
    reset = 1'b1;
    set_in(3'b110, 3'b000, 3'b000);
    step();
    #1;
    chk("rst_gnt", 64'(bus.gnt), 64'(3'b010));
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 99) != 0);
      bus.req       = 3'($urandom);
      bus.lock      = 3'($urandom);
      bus.we        = 3'($urandom);
      bus.req_addr  = (3*AW)'({$urandom, $urandom});
      bus.req_wdata = (3*DW)'({$urandom, $urandom});
      bus.req_sel   = 9'($urandom);
      bus.cdata_rd  = DW'($urandom);
      #1;
      chk("excl", 64'(bus.cwr & bus.crd), 64'd0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
